// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU function / carry-select codes and the multiply sequencer state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [4:0] ALU_F_ZERO       = 5'h00;
  localparam logic [4:0] ALU_F_ADD        = 5'h01;
  localparam logic [4:0] ALU_F_SHIFT_LEFT = 5'h08;

  localparam logic ALU_CSEL_UCIN  = 1'b0;
  localparam logic ALU_CSEL_SRCIN = 1'b1;

  typedef enum logic [1:0] {
    MUL_SEQ_ST_IDLE  = 2'd0,
    MUL_SEQ_ST_ADD   = 2'd1,
    MUL_SEQ_ST_SHIFT = 2'd2,
    MUL_SEQ_ST_DONE  = 2'd3
  } mul_seq_state_e;

endpackage

// File: rtl/alu_mul_seq_regs.sv
// Operand/accumulator register file for the shift-and-add multiplier:
// accumulator, multiplicand, multiplier and shift counter.
// load has priority and initialises everything for a new operation.
module alu_mul_seq_regs #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             load,
  input  logic             acc_cap,
  input  logic             shift_cap,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] mplier,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-value selection: load a new operation, capture an ADD result, or capture a SHIFT step.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = a_in;
      mplier_d = b_in;
      cnt_d    = '0;
    end else begin
      if (acc_cap) begin
        acc_d = alu_y;
      end
      if (shift_cap) begin
        mcand_d  = alu_y;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end
  end

  // Register bank, cleared by the asynchronous active-low reset.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc    = acc_q;
  assign mcand  = mcand_q;
  assign mplier = mplier_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/alu_mul_sequencer.sv
// 16x16->16 unsigned shift-and-add multiplier driving the shared ALU, one ALU op per clock.
// Holds the FSM (IDLE/ADD/SHIFT/DONE) and the ALU drive decode; operand registers live in alu_mul_seq_regs.
// Optional build macro: MUL_SEQ_EARLY_EXIT_EN -- leave SHIFT for DONE as soon as no multiplier bits remain.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             notReset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_f,
  output logic             alu_csel,
  output logic             alu_ucin,
  output logic             alu_srcin,
  output logic             alu_notALUOE,
  output logic             alu_notShiftOE,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_seq_state_e   state_q, state_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             load, acc_cap, shift_cap;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic             more_bits;
  logic             last_shift;

  alu_mul_seq_regs #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_regs (
    .clock    (clock),
    .notReset (notReset),
    .load     (load),
    .acc_cap  (acc_cap),
    .shift_cap(shift_cap),
    .a_in     (a_in),
    .b_in     (b_in),
    .alu_y    (alu_y),
    .acc      (acc),
    .mcand    (mcand),
    .mplier   (mplier),
    .cnt      (cnt)
  );

  // Multiplier bits above the current one: a shifted-out multiplicand bit only overflows if some remain.
  assign more_bits = (mplier >> 1) != '0;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign last_shift = (cnt == CNT_LAST) || !more_bits;
`else
  assign last_shift = (cnt == CNT_LAST);
`endif

  // Next-state and ALU drive decode; the bus is released (both OEs high) unless ADD or SHIFT owns it.
  always_comb begin
    state_d        = state_q;
    ovf_d          = ovf_q;
    result_d       = result_q;
    load           = 1'b0;
    acc_cap        = 1'b0;
    shift_cap      = 1'b0;
    alu_a          = '0;
    alu_b          = '0;
    alu_f          = ALU_F_ZERO;
    alu_csel       = ALU_CSEL_UCIN;
    alu_ucin       = 1'b0;
    alu_notALUOE   = 1'b1;
    alu_notShiftOE = 1'b1;
    case (state_q)
      MUL_SEQ_ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          ovf_d   = 1'b0;
          state_d = b_in[0] ? MUL_SEQ_ST_ADD : MUL_SEQ_ST_SHIFT;
        end
      end
      MUL_SEQ_ST_ADD: begin
        alu_a        = acc;
        alu_b        = mcand;
        alu_f        = ALU_F_ADD;
        alu_notALUOE = 1'b0;
        acc_cap      = 1'b1;
        ovf_d        = ovf_q | alu_cout;
        state_d      = MUL_SEQ_ST_SHIFT;
      end
      MUL_SEQ_ST_SHIFT: begin
        alu_a          = mcand;
        alu_f          = ALU_F_SHIFT_LEFT;
        alu_notShiftOE = 1'b0;
        shift_cap      = 1'b1;
        ovf_d          = ovf_q | (alu_cout & more_bits);
        if (last_shift) begin
          // acc is final here, so loading result on entry to DONE makes it valid in the done cycle.
          result_d = acc;
          state_d  = MUL_SEQ_ST_DONE;
        end else begin
          state_d = mplier[1] ? MUL_SEQ_ST_ADD : MUL_SEQ_ST_SHIFT;
        end
      end
      MUL_SEQ_ST_DONE: begin
        result_d = acc;
        state_d  = MUL_SEQ_ST_IDLE;
      end
      default: begin
        state_d = MUL_SEQ_ST_IDLE;
      end
    endcase
  end

  // State, overflow and result registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q  <= MUL_SEQ_ST_IDLE;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != MUL_SEQ_ST_IDLE);
  assign done      = (state_q == MUL_SEQ_ST_DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign alu_srcin = 1'b0;

endmodule
